// File: rtl/acao_pkg.sv
// acao_pkg: action codes, motor encodings and state type for the toy action sequencer.
package acao_pkg;
  localparam logic [3:0] ACAO_IDLE = 4'd0;
  localparam logic [3:0] ACAO_FRENTE1 = 4'd1;
  localparam logic [3:0] ACAO_ESQUERDA = 4'd2;
  localparam logic [3:0] ACAO_FRENTE2 = 4'd3;
  localparam logic [3:0] ACAO_DIREITA = 4'd4;
  localparam logic [3:0] ACAO_RE = 4'd5;
  localparam logic [1:0] MOT_FRENTE = 2'b10;
  localparam logic [1:0] MOT_RE = 2'b01;
  localparam logic [1:0] MOT_PARA = 2'b00;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRENTE1,
    ST_ESQUERDA,
    ST_FRENTE2,
    ST_DIREITA,
    ST_RE
  } estado_t;
  function automatic logic [3:0] acao_code(input estado_t s);
    case (s)
      ST_FRENTE1:  return ACAO_FRENTE1;
      ST_ESQUERDA: return ACAO_ESQUERDA;
      ST_FRENTE2:  return ACAO_FRENTE2;
      ST_DIREITA:  return ACAO_DIREITA;
      ST_RE:       return ACAO_RE;
      default:     return ACAO_IDLE;
    endcase
  endfunction
  // Packed as {left, right}.
  function automatic logic [3:0] acao_motores(input estado_t s);
    case (s)
      ST_FRENTE1, ST_FRENTE2: return {MOT_FRENTE, MOT_FRENTE};
      ST_ESQUERDA:            return {MOT_RE, MOT_FRENTE};
      ST_DIREITA:             return {MOT_FRENTE, MOT_RE};
      ST_RE:                  return {MOT_RE, MOT_RE};
      default:                return {MOT_PARA, MOT_PARA};
    endcase
  endfunction
endpackage

// File: rtl/acao_timer.sv
// acao_timer: prescaler plus step counter; done pulses on the last tick of the last step.
module acao_timer #(
  parameter int STEP_TICKS = 25000000,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [SW-1:0] i_last,
  output logic          o_done
);
  localparam int PW = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_step;
  logic          w_pre_end;
  assign w_pre_end = r_pre == PW'(STEP_TICKS - 1);
  assign o_done = i_enable && w_pre_end && (r_step == i_last);
  // The owner clears on every state entry, so the step counter never runs past i_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_step <= '0;
    end else if (i_clear) begin
      r_pre <= '0;
      r_step <= '0;
    end else if (i_enable) begin
      r_pre <= w_pre_end ? '0 : r_pre + PW'(1);
      r_step <= w_pre_end ? r_step + SW'(1) : r_step;
    end
  end
endmodule

// File: rtl/sequenciador_acao.sv
// sequenciador_acao: steps the toy through frente/esquerda/frente/direita, with a timed
// reverse manoeuvre when an obstacle appears during a forward action.
module sequenciador_acao
  import acao_pkg::*;
#(
  parameter int STEP_TICKS = 25000000,
  parameter int ACT_STEPS = 4,
  parameter int BACKOFF_STEPS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       obstacle,
  output logic       b3,
  output logic       b2,
  output logic       b1,
  output logic       b0,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       running,
  output logic       seq_done
);
  localparam int MAX_STEPS = (ACT_STEPS > BACKOFF_STEPS) ? ACT_STEPS : BACKOFF_STEPS;
  localparam int SW = (MAX_STEPS > 2) ? $clog2(MAX_STEPS) : 1;
  estado_t       r_state, r_target, w_next;
  logic          r_start_q;
  logic [3:0]    r_code;
  logic [1:0]    r_motor_l, r_motor_r;
  logic          r_running, r_seq_done;
  logic          w_start_edge, w_clr, w_done;
  logic [SW-1:0] w_last;
  assign w_start_edge = start && !r_start_q;
  assign w_clr = (r_state == ST_IDLE) || (w_next != r_state);
  assign w_last = (r_state == ST_RE) ? SW'(BACKOFF_STEPS - 1) : SW'(ACT_STEPS - 1);
  assign {b3, b2, b1, b0} = r_code;
  assign motor_l = r_motor_l;
  assign motor_r = r_motor_r;
  assign running = r_running;
  assign seq_done = r_seq_done;
  acao_timer #(.STEP_TICKS(STEP_TICKS), .SW(SW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .i_clear(w_clr),
    .i_enable(!pause),
    .i_last(w_last),
    .o_done(w_done)
  );
  // Obstacle is checked before done so it wins on the final cycle of a forward action.
  always_comb begin
    w_next = r_state;
    if (!pause)
      case (r_state)
        ST_IDLE:     w_next = w_start_edge ? ST_FRENTE1 : ST_IDLE;
        ST_FRENTE1:  w_next = obstacle ? ST_RE : (w_done ? ST_ESQUERDA : ST_FRENTE1);
        ST_ESQUERDA: w_next = w_done ? ST_FRENTE2 : ST_ESQUERDA;
        ST_FRENTE2:  w_next = obstacle ? ST_RE : (w_done ? ST_DIREITA : ST_FRENTE2);
        ST_DIREITA:  w_next = w_done ? ST_IDLE : ST_DIREITA;
        ST_RE:       w_next = w_done ? r_target : ST_RE;
        default:     w_next = ST_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_target <= ST_ESQUERDA;
      r_start_q <= 1'b0;
      r_code <= ACAO_IDLE;
      r_motor_l <= MOT_PARA;
      r_motor_r <= MOT_PARA;
      r_running <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      r_start_q <= start;
      r_state <= w_next;
      if (w_next == ST_RE && r_state != ST_RE)
        r_target <= (r_state == ST_FRENTE1) ? ST_ESQUERDA : ST_DIREITA;
      r_code <= acao_code(w_next);
      {r_motor_l, r_motor_r} <= pause ? {MOT_PARA, MOT_PARA} : acao_motores(w_next);
      r_running <= w_next != ST_IDLE;
      r_seq_done <= (r_state == ST_DIREITA) && (w_next == ST_IDLE);
    end
  end
endmodule

// File: tb/tb_sequenciador_acao.sv
// tb_sequenciador_acao: directed route scenarios; expected outputs queued per cycle and
// compared by an independent monitor on the falling edge.
module tb_sequenciador_acao;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, obstacle = 1'b0;
  logic       b3, b2, b1, b0, running, seq_done;
  logic [1:0] motor_l, motor_r;
  logic [9:0] q[$];
  logic       prev_p = 1'b0;
  int         total = 0, bad = 0;

  sequenciador_acao #(.STEP_TICKS(4), .ACT_STEPS(3), .BACKOFF_STEPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .obstacle(obstacle),
    .b3(b3), .b2(b2), .b1(b1), .b0(b0), .motor_l(motor_l), .motor_r(motor_r),
    .running(running), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mot(input logic [3:0] c);
    case (c)
      4'd1, 4'd3: return 4'b1010;
      4'd2:       return 4'b0110;
      4'd4:       return 4'b1001;
      4'd5:       return 4'b0101;
      default:    return 4'b0000;
    endcase
  endfunction

  // n cycles showing code c; inputs s/p/o are applied for the next edge.
  task automatic run(input int n, input logic [3:0] c, input logic s, input logic p,
                     input logic o, input logic d = 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      q.push_back({c, prev_p ? 4'b0000 : mot(c), c != 4'd0, d && i == 0});
      prev_p = p;
      start = s;
      pause = p;
      obstacle = o;
    end
  endtask

  task automatic launch();
    run(1, 4'd0, 1'b0, 1'b0, 1'b0);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [9:0] exp_v, got;
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      got = {b3, b2, b1, b0, motor_l, motor_r, running, seq_done};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got code=%0d ml=%b mr=%b run=%b done=%b exp code=%0d ml=%b mr=%b run=%b done=%b",
                 $time, got[9:6], got[5:4], got[3:2], got[1], got[0],
                 exp_v[9:6], exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    run(2, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run(2, 4'd0, 1'b0, 1'b0, 1'b0);
    // plain route, start held high afterwards
    run(1, 4'd0, 1'b1, 1'b0, 1'b0);
    run(12, 4'd1, 1'b1, 1'b0, 1'b0);
    run(12, 4'd2, 1'b1, 1'b0, 1'b0);
    run(12, 4'd3, 1'b1, 1'b0, 1'b0);
    run(12, 4'd4, 1'b1, 1'b0, 1'b0);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(3, 4'd0, 1'b1, 1'b0, 1'b0);
    // obstacle pulse in the 5th FRENTE1 cycle
    launch();
    run(4, 4'd1, 1'b1, 1'b0, 1'b0);
    run(1, 4'd1, 1'b1, 1'b0, 1'b1);
    run(8, 4'd5, 1'b1, 1'b0, 1'b0);
    run(12, 4'd2, 1'b1, 1'b0, 1'b0);
    run(12, 4'd3, 1'b1, 1'b0, 1'b0);
    run(12, 4'd4, 1'b1, 1'b0, 1'b0);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    // obstacle only while turning
    launch();
    run(12, 4'd1, 1'b1, 1'b0, 1'b0);
    run(12, 4'd2, 1'b1, 1'b0, 1'b1);
    run(12, 4'd3, 1'b1, 1'b0, 1'b0);
    run(12, 4'd4, 1'b1, 1'b0, 1'b1);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0);
    // pause 7 cycles in FRENTE2 with obstacle asserted meanwhile
    launch();
    run(12, 4'd1, 1'b1, 1'b0, 1'b0);
    run(12, 4'd2, 1'b1, 1'b0, 1'b0);
    run(5, 4'd3, 1'b1, 1'b0, 1'b0);
    run(7, 4'd3, 1'b1, 1'b1, 1'b1);
    run(7, 4'd3, 1'b1, 1'b0, 1'b0);
    run(12, 4'd4, 1'b1, 1'b0, 1'b0);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    // obstacle on last FRENTE2 cycle, extra start edge mid-route
    launch();
    run(12, 4'd1, 1'b1, 1'b0, 1'b0);
    run(6, 4'd2, 1'b0, 1'b0, 1'b0);
    run(6, 4'd2, 1'b1, 1'b0, 1'b0);
    run(11, 4'd3, 1'b1, 1'b0, 1'b0);
    run(1, 4'd3, 1'b1, 1'b0, 1'b1);
    run(8, 4'd5, 1'b1, 1'b0, 1'b0);
    run(12, 4'd4, 1'b1, 1'b0, 1'b0);
    run(1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(3, 4'd0, 1'b1, 1'b0, 1'b0);
    // async reset in the middle of FRENTE2
    launch();
    run(12, 4'd1, 1'b1, 1'b0, 1'b0);
    run(12, 4'd2, 1'b1, 1'b0, 1'b0);
    run(4, 4'd3, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    q.push_back(10'b0);
    run(2, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run(3, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
